// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared op encodings, default widths and the EX/MEM field list.
package ex_stage_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_RA = 5;
  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_SLT   = 3'd5,
    OP_PASSB = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] result;
    logic [DEF_RA-1:0]    rd;
    logic                 wb_en;
    logic                 zero;
    logic                 neg;
    logic                 carry;
    logic                 ovf;
  } ex_mem_t;
endpackage

// File: rtl/ex_stage_alu32.sv
// alu32: WIDTH-bit ripple ALU built from generate-instantiated per-bit slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

module alu_slice (
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic cin,
  output logic s,
  output logic co,
  output logic an,
  output logic orr,
  output logic xr
);
  logic bx;
  assign bx = b ^ sub;
  full_adder fa (.a(a), .b(bx), .cin(cin), .s(s), .co(co));
  assign an = a & b;
  assign orr = a | b;
  assign xr = a ^ b;
endmodule

module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] and_v,
  output logic [WIDTH-1:0] or_v,
  output logic [WIDTH-1:0] xor_v,
  output logic             cout,
  output logic             cmsb
);
  logic [WIDTH:0] c;
  assign c[0] = sub;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    alu_slice u_slice (
      .a(a[i]), .b(b[i]), .sub(sub), .cin(c[i]),
      .s(sum[i]), .co(c[i+1]), .an(and_v[i]), .orr(or_v[i]), .xr(xor_v[i])
    );
  end
  assign cout = c[WIDTH];
  assign cmsb = c[WIDTH-1];
endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand forwarding, ALU result/flag select and the EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RA = DEF_RA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_op,
  input  logic [RA-1:0]    in_rs_addr,
  input  logic [RA-1:0]    in_rt_addr,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [RA-1:0]    in_rd,
  input  logic             in_wb_en,
  input  logic             fwd_mem_en,
  input  logic [RA-1:0]    fwd_mem_rd,
  input  logic [WIDTH-1:0] fwd_mem_val,
  input  logic             fwd_wb_en,
  input  logic [RA-1:0]    fwd_wb_rd,
  input  logic [WIDTH-1:0] fwd_wb_val,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [RA-1:0]    out_rd,
  output logic             out_wb_en,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);
  logic [WIDTH-1:0] a, b, rt_f, sum, and_v, or_v, xor_v, result;
  logic sub, arith, cout, cmsb, ovf, wb;
  // MEM beats WB; register 0 is hard-wired and never forwarded
  assign a = (in_rs_addr == '0) ? in_rs_val
           : (fwd_mem_en && fwd_mem_rd == in_rs_addr) ? fwd_mem_val
           : (fwd_wb_en && fwd_wb_rd == in_rs_addr) ? fwd_wb_val : in_rs_val;
  assign rt_f = (in_rt_addr == '0) ? in_rt_val
              : (fwd_mem_en && fwd_mem_rd == in_rt_addr) ? fwd_mem_val
              : (fwd_wb_en && fwd_wb_rd == in_rt_addr) ? fwd_wb_val : in_rt_val;
  assign b = in_use_imm ? in_imm : rt_f;
  assign sub = in_op == OP_SUB || in_op == OP_SLT;
  assign arith = in_op == OP_ADD || sub;
  alu32 #(.WIDTH(WIDTH)) u_alu (
    .a(a), .b(b), .sub(sub), .sum(sum), .and_v(and_v), .or_v(or_v),
    .xor_v(xor_v), .cout(cout), .cmsb(cmsb)
  );
  assign ovf = arith & (cmsb ^ cout);
  assign result = (in_op == OP_ADD || in_op == OP_SUB) ? sum
                : (in_op == OP_AND) ? and_v
                : (in_op == OP_OR) ? or_v
                : (in_op == OP_XOR) ? xor_v
                : (in_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ cmsb ^ cout}
                : (in_op == OP_PASSB) ? b : '0;
  assign wb = in_wb_en && in_op != OP_RSVD;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_result <= '0;
      out_rd <= '0;
      out_wb_en <= 1'b0;
      out_zero <= 1'b0;
      out_neg <= 1'b0;
      out_carry <= 1'b0;
      out_ovf <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_result <= in_valid ? result : '0;
      out_rd <= in_valid ? in_rd : '0;
      out_wb_en <= in_valid && wb;
      out_zero <= in_valid && result == '0;
      out_neg <= in_valid && result[WIDTH-1];
      out_carry <= in_valid && arith && cout;
      out_ovf <= in_valid && ovf;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed table, random model comparison and hand sequences for ex_stage.
module tb_ex_stage;
  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] rsv, rtv, imm;
    logic        ui;
    logic [4:0]  rd;
    logic        we;
    logic        men;
    logic [4:0]  mrd;
    logic [31:0] mval;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wval;
    logic [31:0] er;
    logic [3:0]  ef;
    logic        ew;
  } vec_t;

  logic clk = 0, reset = 1;
  logic in_valid = 0, in_use_imm = 0, in_wb_en = 0;
  logic [2:0] in_op = 0;
  logic [4:0] in_rs_addr = 0, in_rt_addr = 0, in_rd = 0, fwd_mem_rd = 0, fwd_wb_rd = 0;
  logic [31:0] in_rs_val = 0, in_rt_val = 0, in_imm = 0, fwd_mem_val = 0, fwd_wb_val = 0;
  logic fwd_mem_en = 0, fwd_wb_en = 0, stall = 0, flush = 0;
  logic out_valid, out_wb_en, out_zero, out_neg, out_carry, out_ovf;
  logic [31:0] out_result;
  logic [4:0] out_rd;
  int checks = 0, errors = 0;
  vec_t tbl[10];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rs_val(in_rs_val),
    .in_rt_val(in_rt_val), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .in_wb_en(in_wb_en), .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_val(fwd_mem_val), .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_val(fwd_wb_val), .stall(stall), .flush(flush), .out_valid(out_valid),
    .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [4:0] addr, input logic [31:0] rf,
      input logic men, input logic [4:0] mrd, input logic [31:0] mval,
      input logic wen, input logic [4:0] wrd, input logic [31:0] wval);
    if (addr == 0) return rf;
    if (men && mrd == addr) return mval;
    if (wen && wrd == addr) return wval;
    return rf;
  endfunction

  // Reference: plain arithmetic from the op definitions, fills expected fields
  function automatic vec_t model(input vec_t v);
    logic [31:0] a, b, r, d;
    logic [32:0] wide;
    logic c, o;
    a = pick(v.rs, v.rsv, v.men, v.mrd, v.mval, v.wen, v.wrd, v.wval);
    b = v.ui ? v.imm : pick(v.rt, v.rtv, v.men, v.mrd, v.mval, v.wen, v.wrd, v.wval);
    d = a - b;
    c = 0;
    o = 0;
    case (v.op)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        c = wide[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin r = d; c = a >= b; o = (a[31] != b[31]) && (d[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        c = a >= b;
        o = (a[31] != b[31]) && (d[31] != a[31]);
      end
      3'd6: r = b;
      default: r = 0;
    endcase
    v.er = v.valid ? r : 0;
    v.ef = v.valid ? {r == 0, r[31], c, o} : 4'b0;
    v.ew = v.valid && v.we && v.op != 3'd7;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    in_valid = v.valid; in_op = v.op; in_rs_addr = v.rs; in_rt_addr = v.rt;
    in_rs_val = v.rsv; in_rt_val = v.rtv; in_imm = v.imm; in_use_imm = v.ui;
    in_rd = v.rd; in_wb_en = v.we; fwd_mem_en = v.men; fwd_mem_rd = v.mrd;
    fwd_mem_val = v.mval; fwd_wb_en = v.wen; fwd_wb_rd = v.wrd; fwd_wb_val = v.wval;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input string name);
    apply(v);
    step();
    chk({name, ".result"}, out_result, v.er);
    chk({name, ".flags"}, {28'b0, out_zero, out_neg, out_carry, out_ovf}, {28'b0, v.ef});
    chk({name, ".wb_en"}, {31'b0, out_wb_en}, {31'b0, v.ew});
    chk({name, ".valid"}, {31'b0, out_valid}, {31'b0, v.valid});
    if (v.valid) chk({name, ".rd"}, {27'b0, out_rd}, {27'b0, v.rd});
  endtask

  initial begin
    vec_t v;
    // valid op rs rt rsv rtv imm ui rd we men mrd mval wen wrd wval | er ef ew
    tbl[0] = '{1, 0, 1, 2, 32'h7FFFFFFF, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 32'h80000000, 4'b0101, 1};
    tbl[1] = '{1, 1, 1, 2, 5, 5, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 1};
    tbl[2] = '{1, 5, 1, 2, 32'hFFFFFFFF, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 1};
    tbl[3] = '{1, 3, 3, 0, 32'h11, 0, 0, 0, 4, 1, 1, 3, 32'hAA, 1, 3, 32'hBB, 32'hAA, 4'b0000, 1};
    tbl[4] = '{1, 3, 0, 0, 32'h55, 0, 0, 0, 4, 1, 1, 0, 32'hAA, 1, 0, 32'hBB, 32'h55, 4'b0000, 1};
    tbl[5] = '{1, 6, 0, 4, 0, 1, 32'h1234, 1, 4, 1, 1, 4, 32'hAA, 0, 0, 0, 32'h1234, 4'b0000, 1};
    tbl[6] = '{1, 7, 1, 2, 1, 2, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0};
    tbl[7] = '{1, 0, 0, 6, 32'h10, 0, 0, 0, 6, 1, 1, 7, 32'h99, 1, 6, 32'hF0, 32'h100, 4'b0000, 1};
    tbl[8] = '{1, 2, 1, 2, 32'hF0F0, 32'hFF00, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 32'hF000, 4'b0000, 0};
    tbl[9] = '{1, 4, 1, 2, 32'h8000FFFF, 32'h0000FFFF, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h80000000, 4'b0100, 1};

    step();
    step();
    chk("reset.valid", {31'b0, out_valid}, 0);
    chk("reset.result", out_result, 0);
    reset = 0;

    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 300; i++) begin
      v.valid = $urandom_range(0, 7) != 0;
      v.op = 3'($urandom_range(0, 7));
      v.rs = 5'($urandom_range(0, 7)); v.rt = 5'($urandom_range(0, 7));
      v.rsv = $urandom; v.rtv = $urandom; v.imm = $urandom;
      v.ui = $urandom_range(0, 1) == 1; v.rd = 5'($urandom);
      v.we = $urandom_range(0, 3) != 0;
      v.men = $urandom_range(0, 1) == 1; v.mrd = 5'($urandom_range(0, 7)); v.mval = $urandom;
      v.wen = $urandom_range(0, 1) == 1; v.wrd = 5'($urandom_range(0, 7)); v.wval = $urandom;
      if (i % 5 == 0) v.rtv = v.rsv;
      run(model(v), $sformatf("rand%0d", i));
    end

    // stall holds for three cycles, then the present inputs are captured
    v = tbl[1];
    v.rsv = 2; v.rtv = 3; v.op = 0; v.we = 1;
    run(model(v), "pre_stall");
    v.op = 4;
    v = model(v);
    apply(v);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.result", i), out_result, 5);
      chk($sformatf("stall%0d.valid", i), {31'b0, out_valid}, 1);
    end
    stall = 0;
    run(v, "post_stall");

    stall = 1;
    flush = 1;
    step();
    chk("flush_stall.valid", {31'b0, out_valid}, 0);
    chk("flush_stall.wb_en", {31'b0, out_wb_en}, 0);
    chk("flush_stall.result", out_result, 0);
    stall = 0;
    flush = 0;

    v = tbl[0];
    v.valid = 0;
    run(model(v), "bubble");

    // asynchronous reset mid-cycle, held output until the edge after release
    run(tbl[0], "pre_reset");
    #2 reset = 1;
    #1;
    chk("async_reset.valid", {31'b0, out_valid}, 0);
    chk("async_reset.result", out_result, 0);
    chk("async_reset.wb_en", {31'b0, out_wb_en}, 0);
    step();
    reset = 0;
    #2;
    chk("post_release.valid", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1;
    chk("first_capture.valid", {31'b0, out_valid}, 1);
    chk("first_capture.result", out_result, 32'h80000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
